// File: rtl/timer_pkg.sv
// timer_pkg: shared width/reset defaults and the timer word type.
package timer_pkg;
  localparam int          DEF_TIM_W   = 16;
  localparam logic [15:0] DEF_ARR_RST = 16'hFFFF;

  typedef logic [DEF_TIM_W-1:0] tim_word_t;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the enabled clock by (psc_act+1), emitting a one-cycle tick.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int TIM_W = DEF_TIM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [TIM_W-1:0] psc_act,
  output logic             tick
);
  logic [TIM_W-1:0] r_psc_cnt;
  logic             w_match;

  // >= rather than == so a prescaler value lowered while disabled cannot strand the count above it
  assign w_match = (r_psc_cnt >= psc_act);
  assign tick    = en && w_match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psc_cnt <= '0;
    end else if (clr) begin
      r_psc_cnt <= '0;
    end else if (en) begin
      if (w_match) r_psc_cnt <= '0;
      else         r_psc_cnt <= r_psc_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/timer_unit.sv
// timer_unit: prescaled up-counter with buffered auto-reload, update event and sticky IRQ flag.
// Defining TIMER_PWM_EN adds a buffered compare register and a registered PWM output.
module timer_unit
  import timer_pkg::*;
#(
  parameter int               TIM_W   = DEF_TIM_W,
  parameter logic [TIM_W-1:0] ARR_RST = DEF_ARR_RST
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TIMER_PWM_EN
  input  logic             ccr_wr,
  input  logic [TIM_W-1:0] TIM_CCR,
  output logic             pwm_out,
`endif
  input  logic [TIM_W-1:0] TIM_PSC,
  input  logic [TIM_W-1:0] TIM_ARR,
  input  logic             psc_wr,
  input  logic             arr_wr,
  input  logic             tim_en,
  input  logic             ug,
  input  logic             irq_clr,
  output logic [TIM_W-1:0] cnt,
  output logic             uev,
  output logic             irq_flag
);
  logic [TIM_W-1:0] r_psc_pre, r_psc_act, r_arr_pre, r_arr_act, r_cnt;
  logic             r_uev, r_irq;
  logic             w_tick, w_wrap, w_xfer;

  timer_prescaler #(.TIM_W(TIM_W)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (tim_en),
    .clr     (ug),
    .psc_act (r_psc_act),
    .tick    (w_tick)
  );

  // Software update overrides a coincident natural wrap; active registers reload on any update or while idle
  assign w_wrap = w_tick && !ug && (r_cnt == r_arr_act);
  assign w_xfer = ug || !tim_en || w_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psc_pre <= '0;
      r_psc_act <= '0;
      r_arr_pre <= ARR_RST;
      r_arr_act <= ARR_RST;
    end else begin
      if (psc_wr) r_psc_pre <= TIM_PSC;
      if (arr_wr) r_arr_pre <= TIM_ARR;
      if (w_xfer) begin
        r_psc_act <= r_psc_pre;
        r_arr_act <= r_arr_pre;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_uev <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_uev <= ug || w_wrap;
      if (ug) begin
        r_cnt <= '0;
      end else if (!tim_en) begin
        // An idle transfer that shrinks the reload below the held count restarts from zero
        if (r_arr_pre < r_cnt) r_cnt <= '0;
      end else if (w_tick) begin
        if (w_wrap) r_cnt <= '0;
        else        r_cnt <= r_cnt + 1'b1;
      end
      if (w_wrap)       r_irq <= 1'b1;
      else if (irq_clr) r_irq <= 1'b0;
    end
  end

  assign cnt      = r_cnt;
  assign uev      = r_uev;
  assign irq_flag = r_irq;

`ifdef TIMER_PWM_EN
  logic [TIM_W-1:0] r_ccr_pre, r_ccr_act;
  logic             r_pwm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ccr_pre <= '0;
      r_ccr_act <= '0;
      r_pwm     <= 1'b0;
    end else begin
      if (ccr_wr) r_ccr_pre <= TIM_CCR;
      if (w_xfer) r_ccr_act <= r_ccr_pre;
      r_pwm <= (r_cnt < r_ccr_act);
    end
  end

  assign pwm_out = r_pwm;
`endif
endmodule
